// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma rotor configuration path.
//   ROTOR_CNT  : number of rotors configured per sequence
//   POS_W      : width of a rotor position
//   POS_MAX    : highest legal rotor position (A..Z -> 0..25)
//   SEL_W      : width of the slot-select bus
//   SEL_COMMIT : slot-select code that tells the receiver to commit/enable
//   state_t    : transmitter FSM states
package enigma_pkg;

    localparam int                  ROTOR_CNT  = 3;
    localparam int                  POS_W      = 5;
    localparam logic [POS_W-1:0]    POS_MAX    = 5'd25;
    localparam int                  SEL_W      = 2;
    localparam logic [SEL_W-1:0]    SEL_COMMIT = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StCommit
    } state_t;

endpackage

// File: rtl/rotor_config_tx_if.sv
// Rotor configuration bus between the transmitter and the rotor bank.
//   pozitie_rotor_out    : slot select (0..2 = rotor, SEL_COMMIT = commit)
//   pozitie_initiala_out : initial position for the selected slot
//   cfg_valid_out        : qualifies both fields; receiver ignores them while low
// Modports: master = transmitter, slave = receiver.
interface rotor_config_tx_if;
    import enigma_pkg::*;

    logic [SEL_W-1:0] pozitie_rotor_out;
    logic [POS_W-1:0] pozitie_initiala_out;
    logic             cfg_valid_out;

    modport master (
        output pozitie_rotor_out,
        output pozitie_initiala_out,
        output cfg_valid_out
    );

    modport slave (
        input pozitie_rotor_out,
        input pozitie_initiala_out,
        input cfg_valid_out
    );

endinterface

// File: rtl/rotor_config_tx.sv
// Sends one rotor configuration: three slots (rotor 0, 1, 2), each held for
// HOLD_CYCLES clocks, followed by a single commit cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   start_in          : request a sequence (sampled only while idle)
//   abort_in          : cancel a sequence while slots are being sent
//   pozitie_{1,2,3}_in: initial positions for rotors 1..3 (legal 0..25)
//   cfg               : configuration bus (master side)
//   busy_out          : high from the first slot cycle through commit
//   done_out          : one-cycle pulse on the commit cycle
//   err_out           : one-cycle pulse when a request has an illegal position
module rotor_config_tx
    import enigma_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [POS_W-1:0]  pozitie_1_in,
    input  logic [POS_W-1:0]  pozitie_2_in,
    input  logic [POS_W-1:0]  pozitie_3_in,
    rotor_config_tx_if.master cfg,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    // Counter counts down to zero, so it is loaded with HOLD_CYCLES-1.
    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [SEL_W-1:0] slot_q;
    logic [3:0]       hold_q;
    logic [POS_W-1:0] pos_q [ROTOR_CNT];

    logic [SEL_W-1:0] slot_nxt;
    logic             bad_req;

    assign slot_nxt = slot_q + 2'd1;
    assign bad_req  = (pozitie_1_in > POS_MAX) || (pozitie_2_in > POS_MAX) ||
                      (pozitie_3_in > POS_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                  <= StIdle;
            slot_q                   <= '0;
            hold_q                   <= '0;
            pos_q                    <= '{default: '0};
            cfg.pozitie_rotor_out    <= '0;
            cfg.pozitie_initiala_out <= '0;
            cfg.cfg_valid_out        <= 1'b0;
            busy_out                 <= 1'b0;
            done_out                 <= 1'b0;
            err_out                  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            err_out  <= 1'b0;
            case (state_q)
                StIdle: begin
                    // start_in wins over abort_in here; abort has no meaning in idle.
                    if (start_in) begin
                        pos_q[0] <= pozitie_1_in;
                        pos_q[1] <= pozitie_2_in;
                        pos_q[2] <= pozitie_3_in;
                        if (bad_req) begin
                            err_out <= 1'b1;
                        end else begin
                            state_q                  <= StSend;
                            slot_q                   <= '0;
                            hold_q                   <= HoldLoad;
                            cfg.pozitie_rotor_out    <= '0;
                            cfg.pozitie_initiala_out <= pozitie_1_in;
                            cfg.cfg_valid_out        <= 1'b1;
                            busy_out                 <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (abort_in) begin
                        state_q                  <= StIdle;
                        slot_q                   <= '0;
                        hold_q                   <= '0;
                        cfg.pozitie_rotor_out    <= '0;
                        cfg.pozitie_initiala_out <= '0;
                        cfg.cfg_valid_out        <= 1'b0;
                        busy_out                 <= 1'b0;
                    end else if (hold_q != 4'd0) begin
                        hold_q <= hold_q - 4'd1;
                    end else if (slot_q == SEL_W'(ROTOR_CNT - 1)) begin
                        state_q                  <= StCommit;
                        cfg.pozitie_rotor_out    <= SEL_COMMIT;
                        cfg.pozitie_initiala_out <= '0;
                        done_out                 <= 1'b1;
                    end else begin
                        slot_q                   <= slot_nxt;
                        hold_q                   <= HoldLoad;
                        cfg.pozitie_rotor_out    <= slot_nxt;
                        cfg.pozitie_initiala_out <= pos_q[slot_nxt];
                    end
                end
                StCommit: begin
                    // Single cycle; abort_in and start_in are ignored here.
                    state_q                  <= StIdle;
                    slot_q                   <= '0;
                    hold_q                   <= '0;
                    cfg.pozitie_rotor_out    <= '0;
                    cfg.pozitie_initiala_out <= '0;
                    cfg.cfg_valid_out        <= 1'b0;
                    busy_out                 <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
